// File: rtl/bus_arbiter_2m.sv
// bus_arbiter_2m: shares one bstart/bdone slave between m0 (ifetch) and m1 (load/store), round-robin on ties.
// Latency: request seen in IDLE -> s_bstart next cycle -> master bdone same cycle as s_bdone (3 cycles, 1-cycle slave).
// Backpressure: masters hold bstart until bdone; a silent slave is aborted with berr after TIMEOUT WAIT cycles.

module bus_arbiter_2m #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 16,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_bstart,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_we,
  output logic          m0_bdone,
  output logic          m0_berr,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_bstart,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_we,
  output logic          m1_bdone,
  output logic          m1_berr,
  output logic [DW-1:0] m1_rdata,
  output logic          s_bstart,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_we,
  input  logic          s_bdone,
  input  logic [DW-1:0] s_rdata,
  output logic [1:0]    gnt
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen in the last WAIT cycle before a timeout abort.
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;   // 0 = m0, 1 = m1
  logic          last_q, last_d;     // master served most recently
  logic [CW-1:0] cnt_q, cnt_d;

  logic slv_done;
  logic tmo_abort;
  logic xfer_end;

  // s_bdone takes priority over a timeout landing in the same cycle.
  assign slv_done  = (state_q == ST_WAIT) && s_bdone;
  assign tmo_abort = (state_q == ST_WAIT) && !s_bdone && (TIMEOUT > 0) && (cnt_q == CNT_LAST);
  assign xfer_end  = slv_done || tmo_abort;

  // State register; reset drops any in-flight transaction and gives m0 the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: arbitrate in IDLE, one ISSUE cycle, then WAIT for slave or timeout.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_bstart || m1_bstart) begin
          state_d = ST_ISSUE;
          if (m0_bstart && m1_bstart) owner_d = ~last_q;
          else                        owner_d = m1_bstart;
        end
      end
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (xfer_end) begin
          last_d  = owner_q;
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_SAT) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: slave bus muxed from the owner outside IDLE, completion routed only to the owner.
  always_comb begin
    gnt      = 2'b00;
    s_bstart = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_we     = 1'b0;
    m0_bdone = 1'b0;
    m0_berr  = 1'b0;
    m0_rdata = '0;
    m1_bdone = 1'b0;
    m1_berr  = 1'b0;
    m1_rdata = '0;
    if (state_q != ST_IDLE) begin
      gnt     = owner_q ? 2'b10 : 2'b01;
      s_addr  = owner_q ? m1_addr  : m0_addr;
      s_wdata = owner_q ? m1_wdata : m0_wdata;
      s_we    = owner_q ? m1_we    : m0_we;
    end
    s_bstart = (state_q == ST_ISSUE);
    if (xfer_end) begin
      if (owner_q) begin
        m1_bdone = 1'b1;
        m1_berr  = tmo_abort;
        m1_rdata = slv_done ? s_rdata : ERR_DATA;
      end else begin
        m0_bdone = 1'b1;
        m0_berr  = tmo_abort;
        m0_rdata = slv_done ? s_rdata : ERR_DATA;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// tb_bus_arbiter_2m: directed cases with literal expectations, then random traffic vs a transaction-level model.
// The model tracks busy/owner/age-since-grant and derives every output from those each cycle.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.

module tb_bus_arbiter_2m;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req [2];
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wdat [2];
  logic          we [2];
  logic          s_bdone;
  logic [DW-1:0] s_rdata;

  logic          m0_bdone, m0_berr, m1_bdone, m1_berr;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          s_bstart, s_we;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [1:0]    gnt;

  logic m0_bstart, m1_bstart, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  assign m0_bstart = req[0];
  assign m1_bstart = req[1];
  assign m0_addr   = addr[0];
  assign m1_addr   = addr[1];
  assign m0_wdata  = wdat[0];
  assign m1_wdata  = wdat[1];
  assign m0_we     = we[0];
  assign m1_we     = we[1];

  bus_arbiter_2m #(.AW(AW), .DW(DW), .TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_bstart(m0_bstart), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_bdone(m0_bdone), .m0_berr(m0_berr), .m0_rdata(m0_rdata),
    .m1_bstart(m1_bstart), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_bdone(m1_bdone), .m1_berr(m1_berr), .m1_rdata(m1_rdata),
    .s_bstart(s_bstart), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we),
    .s_bdone(s_bdone), .s_rdata(s_rdata), .gnt(gnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one transaction at a time, age 0 is the issue cycle.
  bit   mb_busy = 1'b0;
  int   mb_who  = 0;
  int   mb_age  = 0;
  int   mb_last = 1;
  logic ex_done [2] = '{1'b0, 1'b0};

  initial begin
    logic          e_sb, e_we, fin;
    logic [1:0]    e_gnt;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd;
    logic          e_done [2];
    logic          e_err [2];
    logic [DW-1:0] e_rd [2];
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mb_busy = 1'b0;
        mb_last = 1;
      end else if (mb_busy) begin
        if (ex_done[mb_who]) begin
          mb_busy = 1'b0;
          mb_last = mb_who;
        end else begin
          mb_age++;
        end
      end else if (req[0] || req[1]) begin
        mb_busy = 1'b1;
        mb_age  = 0;
        mb_who  = (req[0] && req[1]) ? 1 - mb_last : (req[1] ? 1 : 0);
      end

      @(negedge clk);
      if (!rst_n) begin
        mb_busy = 1'b0;
        mb_last = 1;
      end
      e_gnt = 2'b00; e_sb = 1'b0; e_addr = '0; e_wd = '0; e_we = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e_done[i] = 1'b0; e_err[i] = 1'b0; e_rd[i] = '0;
      end
      if (mb_busy) begin
        e_gnt  = (mb_who == 1) ? 2'b10 : 2'b01;
        e_sb   = (mb_age == 0);
        e_addr = addr[mb_who];
        e_wd   = wdat[mb_who];
        e_we   = we[mb_who];
        fin    = (mb_age >= 1) && (s_bdone || mb_age == TO);
        if (fin) begin
          e_done[mb_who] = 1'b1;
          e_err[mb_who]  = !s_bdone;
          e_rd[mb_who]   = s_bdone ? s_rdata : ERRD;
        end
      end
      ex_done[0] = e_done[0];
      ex_done[1] = e_done[1];
      chk("gnt", gnt, e_gnt);
      chk("s_bstart", s_bstart, e_sb);
      chk("s_addr", s_addr, e_addr);
      chk("s_wdata", s_wdata, e_wd);
      chk("s_we", s_we, e_we);
      chk("m0_bdone", m0_bdone, e_done[0]);
      chk("m0_berr", m0_berr, e_err[0]);
      chk("m0_rdata", m0_rdata, e_rd[0]);
      chk("m1_bdone", m1_bdone, e_done[1]);
      chk("m1_berr", m1_berr, e_err[1]);
      chk("m1_rdata", m1_rdata, e_rd[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req(input int i);
    req[i]  = 1'b1;
    addr[i] = $urandom;
    wdat[i] = $urandom;
    we[i]   = 1'($urandom_range(0, 1));
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = '0; wdat[i] = '0; we[i] = 1'b0;
    end
    s_bdone = 1'b0;
    s_rdata = '0;
    step(); step();
    @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_s_bstart", s_bstart, 1'b0);
    chk("rst_m0_bdone", m0_bdone, 1'b0);
    step(); rst_n = 1'b1;

    // Single m0 read of 0x004, slave answers one cycle after s_bstart.
    step(); req[0] = 1'b1; addr[0] = 32'h4; wdat[0] = 32'h0; we[0] = 1'b0;
    @(negedge clk); chk("rd_c0_s_bstart", s_bstart, 1'b0);
    step();
    @(negedge clk); chk("rd_c1_s_bstart", s_bstart, 1'b1); chk("rd_c1_s_addr", s_addr, 32'h4);
    step(); s_bdone = 1'b1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    chk("rd_c2_m0_bdone", m0_bdone, 1'b1);
    chk("rd_c2_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("rd_c2_m1_bdone", m1_bdone, 1'b0);
    chk("rd_c2_s_bstart", s_bstart, 1'b0);
    step(); req[0] = 1'b0; s_bdone = 1'b0;
    @(negedge clk); chk("rd_c3_gnt", gnt, 2'b00);

    // Silent slave: abort in the 4th WAIT cycle (cycle 5).
    step(); req[0] = 1'b1;
    step(); step(); step(); step();
    @(negedge clk); chk("to_c4_m0_bdone", m0_bdone, 1'b0);
    step();
    @(negedge clk);
    chk("to_c5_m0_bdone", m0_bdone, 1'b1);
    chk("to_c5_m0_berr", m0_berr, 1'b1);
    chk("to_c5_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    step(); req[0] = 1'b0;
    @(negedge clk); chk("to_after_gnt", gnt, 2'b00);

    // Reset during an m1 WAIT (last is m0 here); afterwards a tie must go to m0.
    step(); req[1] = 1'b1;
    step(); step();
    step(); rst_n = 1'b0;
    @(negedge clk);
    chk("rstw_gnt", gnt, 2'b00);
    chk("rstw_m1_bdone", m1_bdone, 1'b0);
    chk("rstw_s_addr", s_addr, 32'h0);
    step(); rst_n = 1'b1; req[0] = 1'b1;
    @(negedge clk); chk("rstw_idle_gnt", gnt, 2'b00);
    step();
    @(negedge clk); chk("rstw_tie_gnt", gnt, 2'b01);
    // m0 drops bstart while granted; completion still reaches it.
    step(); s_bdone = 1'b1; req[0] = 1'b0;
    @(negedge clk); chk("drop_m0_bdone", m0_bdone, 1'b1);
    step(); step(); step();
    @(negedge clk); chk("rstw_m1_bdone_late", m1_bdone, 1'b1);
    step(); req[1] = 1'b0; s_bdone = 1'b0;

    // Spurious s_bdone in IDLE and ISSUE.
    step(); s_bdone = 1'b1;
    @(negedge clk); chk("sp_idle_m0", m0_bdone, 1'b0); chk("sp_idle_m1", m1_bdone, 1'b0);
    step(); req[1] = 1'b1;
    step();
    @(negedge clk); chk("sp_issue_m1", m1_bdone, 1'b0); chk("sp_issue_s_bstart", s_bstart, 1'b1);
    step(); s_bdone = 1'b0;
    @(negedge clk); chk("sp_wait1_m1", m1_bdone, 1'b0);
    step(); s_bdone = 1'b1; s_rdata = 32'hA5A5_0001;
    @(negedge clk); chk("sp_wait2_m1", m1_bdone, 1'b1); chk("sp_wait2_rdata", m1_rdata, 32'hA5A5_0001);
    step(); req[1] = 1'b0;

    // Continuous tie, slave always ready: m0, m1, m0, m1 at 3 cycles each.
    step(); req[0] = 1'b1; req[1] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      @(negedge clk); chk("tie_gnt", gnt, (t % 2 == 0) ? 2'b01 : 2'b10);
      step(); step();
    end
    req[0] = 1'b0; req[1] = 1'b0;

    // Lone m1 back-to-back: bdone at cycles 2 and 5.
    step(); req[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      @(negedge clk); chk("m1_b2b_bdone", m1_bdone, (c == 2 || c == 5));
    end
    step(); req[1] = 1'b0; s_bdone = 1'b0;

    // Random traffic; the model process checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_n = ($urandom_range(0, 799) != 0);
      for (int i = 0; i < 2; i++) begin
        if (req[i] && ex_done[i]) begin
          if ($urandom_range(0, 1) == 1) new_req(i);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 3) == 0) begin
          new_req(i);
        end
      end
      s_bdone = ($urandom_range(0, 3) == 0);
      s_rdata = $urandom;
    end
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_2m.md
# bus_arbiter_2m

Two-master, one-slave arbiter for the SoC's bstart/bdone slave bus. It shares one slave, such as the boot ROM, between the instruction-fetch master (m0) and the load/store master (m1). It applies round-robin on contention, issues a one-cycle bstart to the slave, returns the slave's bdone and rdata to the granted master, and aborts with an error if the slave does not respond within TIMEOUT cycles.

## Interface
- AW, 32: address width
- DW, 32: data width
- TIMEOUT, 16: maximum cycles spent in WAIT before abort; 0 disables the timeout
- ERR_DATA, 32'hDEAD_BEEF: rdata returned to the master on a timeout abort
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- m0_bstart, m1_bstart  in  1  request; held high with addr/wdata/we stable until that master's bdone
- m0_addr, m1_addr  in  AW  request address
- m0_wdata, m1_wdata  in  DW  write data
- m0_we, m1_we  in  1  write enable
- m0_bdone, m1_bdone  out  1  one-cycle completion pulse
- m0_berr, m1_berr  out  1  high together with bdone on a timeout abort
- m0_rdata, m1_rdata  out  DW  read data, valid only while that master's bdone is high
- s_bstart  out  1  one-cycle start pulse to the slave
- s_addr  out  AW  address to the slave
- s_wdata  out  DW  write data to the slave
- s_we  out  1  write enable to the slave
- s_bdone  in  1  slave completion
- s_rdata  in  DW  slave read data
- gnt  out  2  one-hot current owner (bit 0 = m0, bit 1 = m1); 0 when idle

## Operation
- FSM states: IDLE, ISSUE, WAIT. Reset state is IDLE.
- IDLE:
  - No request: stay in IDLE.
  - Any mN_bstart high: pick a winner, register it in `owner`, go to ISSUE.
  - Arbitration: a single requester wins. If both request, the master not equal to `last` wins.
  - `last` resets to 1, so m0 wins the first tie.
- ISSUE:
  - s_bstart=1 for exactly this cycle.
  - s_addr, s_wdata and s_we are muxed from `owner`.
  - Clear the timeout counter and go to WAIT unconditionally.
  - s_bdone is ignored in this state.
- WAIT:
  - s_bstart=0; the slave bus is still muxed from `owner`.
  - s_bdone=1: assert m[owner]_bdone combinationally in the same cycle, with m[owner]_rdata=s_rdata. Set `last`=`owner` and go to IDLE.
  - Otherwise, with TIMEOUT>0: increment the counter. When the counter equals TIMEOUT-1 and s_bdone is still low, abort: m[owner]_bdone=1, m[owner]_berr=1, rdata=ERR_DATA. Set `last`=`owner` and go to IDLE.
  - s_bdone and the timeout in the same cycle: s_bdone wins and berr stays 0.
- Non-owner master: its bdone, berr and rdata stay 0 for the whole transaction.
- In IDLE: s_addr, s_wdata and s_we are driven to 0, and gnt=0.
- s_bdone arriving in IDLE is ignored and forwarded to no master.
- A master that drops bstart while it is granted: the transaction still completes and bdone still pulses to it.
- Counter width: $clog2(TIMEOUT+1) bits (minimum 1). The counter saturates and never wraps.
- Reset, asserted at any time: FSM goes to IDLE, `last` goes to 1, the counter clears, and any in-flight transaction is dropped without bdone.

## Timing
- Reset values: s_bstart, s_addr, s_wdata, s_we, gnt, both bdone, both berr and both rdata are all 0.
- Request seen in IDLE at cycle 0: ISSUE at cycle 1, WAIT from cycle 2.
- With the ROM's one-cycle response, master bdone appears in cycle 2, so latency is 3 cycles.
- Back-to-back requests: a master whose bstart is still high in the cycle after its bdone is treated as making a new request. Throughput is one transaction per 3 cycles.
- Timeout abort: bdone and berr pulse in the TIMEOUT-th WAIT cycle, i.e. cycle TIMEOUT+1 after ISSUE.

## Test plan
- Single m0 read of addr 0x004, with a slave returning 0x1234_5678 one cycle after s_bstart:
  - s_bstart high only in cycle 1 and s_addr=0x004.
  - m0_bdone in cycle 2 with m0_rdata=0x1234_5678; m1_bdone stays 0.
- m0 and m1 requesting simultaneously and continuously for 4 transactions: grants go m0, m1, m0, m1, each taking 3 cycles.
- m1 requesting alone twice back-to-back: m1 granted both times (round-robin does not starve a lone requester), with bdone at cycles 2 and 5.
- TIMEOUT=4 with a slave that never responds:
  - m0_bdone=1, m0_berr=1 and m0_rdata=0xDEAD_BEEF in the 4th WAIT cycle.
  - FSM then back in IDLE with gnt=0.
- rst_n pulsed low during WAIT: all outputs 0 immediately, no bdone for the dropped transaction. After release, a tied request is granted to m0.
- Spurious s_bdone in IDLE and in ISSUE: no mN_bdone asserted, and the transaction completes normally on the later real s_bdone.
